// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks instruction memory from a start address into a
// two-entry buffer until a halt opcode is fetched, then drains and reports halted.
module fetch_sequencer #(
    parameter int          DEPTH   = 2,
    parameter logic [5:0]  HALT_OP = 6'b011111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [8:0]  start_pc,
    input  logic        redirect,
    input  logic [8:0]  redirect_pc,
    output logic [8:0]  mem_address,
    output logic        mem_write_enable,
    output logic        mem_mode,
    output logic [31:0] mem_datain,
    input  logic [31:0] mem_dataout,
    output logic [31:0] instr,
    output logic [8:0]  instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        busy,
    output logic        halted,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [1:0] L_DEPTH = 2'(DEPTH);

    state_t      r_state;
    state_t      w_state_next;
    logic [8:0]  r_pc;
    logic [8:0]  w_pc_next;
    logic [1:0]  r_count;
    logic        r_head;
    logic        r_tail;
    logic [31:0] r_buf_instr [DEPTH];
    logic [8:0]  r_buf_pc    [DEPTH];
    logic        w_flush;
    logic        w_push;
    logic        w_pop;
    logic        w_is_halt;

    // Consumer handshake: the head entry transfers on any cycle where instr_valid and
    // instr_ready are both high, unless a start/redirect flush claims that cycle.
    assign instr_valid      = (r_count != 2'd0);
    assign instr            = r_buf_instr[r_head];
    assign instr_pc         = r_buf_pc[r_head];
    assign mem_address      = r_pc;
    assign mem_write_enable = 1'b0;
    assign mem_mode         = 1'b0;
    assign mem_datain       = 32'd0;
    assign busy             = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign halted           = (r_state == S_HALT);
    assign dbg_state        = r_state;
    assign w_is_halt        = (mem_dataout[31:26] == HALT_OP);

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_flush      = 1'b0;
        w_push       = 1'b0;
        w_pop        = instr_valid && instr_ready;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    w_flush      = 1'b1;
                    w_pop        = 1'b0;
                    w_pc_next    = start_pc;
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (redirect) begin
                    w_flush      = 1'b1;
                    w_pop        = 1'b0;
                    w_pc_next    = redirect_pc;
                    w_state_next = S_FETCH;
                end else if (r_count < L_DEPTH) begin
                    // Room is judged on the registered count so a same-cycle pop never
                    // opens a slot combinationally.
                    w_push = 1'b1;
                    if (w_is_halt) begin
                        w_state_next = S_DRAIN;
                    end else begin
                        w_pc_next = r_pc + 9'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (redirect) begin
                    w_flush      = 1'b1;
                    w_pop        = 1'b0;
                    w_pc_next    = redirect_pc;
                    w_state_next = S_FETCH;
                end else if (r_count == 2'd0) begin
                    w_state_next = S_HALT;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pc    <= 9'd0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_instr[i] <= 32'd0;
                r_buf_pc[i]    <= 9'd0;
            end
        end else if (w_flush) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
        end else begin
            if (w_push) begin
                r_buf_instr[r_tail] <= mem_dataout;
                r_buf_pc[r_tail]    <= r_pc;
                r_tail              <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL provide parameter DEPTH, default 2, instruction buffer entries (fixed 2 for this release).
REQ-002 SHALL provide parameter HALT_OP, default 6'b011111, opcode [31:26] that ends a fetch run.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-005 start  input  1  begin fetching at start_pc; honoured only in IDLE or HALT.
REQ-006 start_pc  input  9  first fetch address.
REQ-007 redirect  input  1  branch/jump redirect; honoured only in FETCH or DRAIN.
REQ-008 redirect_pc  input  9  new fetch address on redirect.
REQ-009 mem_address  output  9  read address to instruction memory, equal to registered pc.
REQ-010 mem_write_enable  output  1  tied 0 (read-only initiator).
REQ-011 mem_mode  output  1  tied 0.
REQ-012 mem_datain  output  32  tied 0.
REQ-013 mem_dataout  input  32  memory read data, combinational from mem_address in same cycle.
REQ-014 instr  output  32  instruction at buffer head.
REQ-015 instr_pc  output  9  address of instruction at buffer head.
REQ-016 instr_valid  output  1  buffer non-empty.
REQ-017 instr_ready  input  1  consumer accepts head this cycle.
REQ-018 busy  output  1  high in FETCH or DRAIN.
REQ-019 halted  output  1  high in HALT.

Function
REQ-020 SHALL implement states IDLE, FETCH, DRAIN, HALT in a registered state machine.
REQ-021 IDLE/HALT + start=1 SHALL load pc<=start_pc, flush buffer, go to FETCH.
REQ-022 In FETCH, when buffer count<DEPTH (registered count, pop ignored), SHALL push {mem_dataout, pc} and increment pc by 1 modulo 512 (511 wraps to 0).
REQ-023 In FETCH with buffer full, SHALL neither push nor advance pc; mem_address holds.
REQ-024 A pushed word with [31:26]==HALT_OP SHALL be pushed, pc SHALL NOT advance, state SHALL go to DRAIN.
REQ-025 In DRAIN, no pushes; when count reaches 0 (after pop), state SHALL go to HALT the following cycle.
REQ-026 Pop SHALL occur when instr_valid && instr_ready; head advances next edge; push and pop in same cycle SHALL leave count unchanged.
REQ-027 instr/instr_pc SHALL show the head entry with zero latency from buffer state; instr_valid = (count!=0).
REQ-028 redirect in FETCH/DRAIN SHALL take priority over push and pop: flush buffer (count<=0), pc<=redirect_pc, state<=FETCH; no push and no pop that cycle.
REQ-029 start during FETCH/DRAIN and redirect during IDLE/HALT SHALL be ignored.
REQ-030 Fetch latency: first instruction valid one cycle after the cycle FETCH is entered.
REQ-031 Sustained throughput with instr_ready=1 SHALL be one instruction per cycle.
REQ-032 In IDLE/HALT, buffer contents SHALL not change except by pop; the consumer may still drain.

Reset
REQ-033 rst=0 SHALL immediately force state IDLE, pc=0, count=0, buffer pointers 0, all buffer entries 0.
REQ-034 During reset: mem_address=0, instr=0, instr_pc=0, instr_valid=0, busy=0, halted=0.
REQ-035 Reset asserted mid-FETCH SHALL discard all buffered instructions; no pop is reported after reset release until a new start.
REQ-036 After rst returns to 1, block SHALL remain in IDLE until start.

Verification
REQ-037 Memory 0..3 = 0x5C100064,0x5C080000,0x5C090000,0x7E150004; start_pc=0, ready=1 -> instr_pc 0,1,2,3 on consecutive cycles, then DRAIN, halted=1 two cycles after last pop.
REQ-038 ready=0 after start -> exactly 2 entries (pc 0,1), mem_address holds 2; ready=1 -> resumes pc 2 with no gap, no duplicate.
REQ-039 redirect with redirect_pc=20 while count=2 -> instr_valid=0 next cycle, next instr_pc=20; flushed entries never popped.
REQ-040 start_pc=510, memory non-halt at 510,511 and halt at 0 -> instr_pc 510,511,0, then HALT.
REQ-041 Assert rst=0 mid-FETCH with count=1 -> outputs zero asynchronously; after release, idle with instr_valid=0 until start.
REQ-042 start and redirect asserted in HALT simultaneously -> start honoured, pc=start_pc, redirect ignored.
